// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and helpers for the serial datapath blocks. These are the PISO
// serializer and the planned serial receiver.
//   ser_state_t : two-state shifter FSM encoding
//   cnt_w(n)    : width of a bit counter that runs 0..n-1
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Counts the bit transfers of one word. It runs 0..N-1. When enabled at the
// terminal count it returns to 0, ready for the next word. It never goes past
// N-1.
// Ports:
//   clk      in   clock
//   clear_i  in   synchronous active-high clear (count -> 0)
//   en_i     in   advance by one bit this cycle
//   count_o  out  current bit index, cnt_w(N) bits
//   tc_o     out  count_o == N-1 (current bit is the last of the word)
// -----------------------------------------------------------------------------
module bit_counter
  import serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  clear_i,
  input  logic                  en_i,
  output logic [cnt_w(N)-1:0]   count_o,
  output logic                  tc_o
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o    = (cnt_q == CW'(N - 1));
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out unloader. It accepts N-bit words and shifts them out
// one bit per transfer. A one-word holding buffer lets the next word start on
// the cycle after the previous word's last bit, so there is no idle cycle.
//
// Handshakes (both ports use strict valid/ready):
//   word accept  = load && ready           at posedge
//   bit transfer = sout_valid && sout_ready at posedge
//   ready depends only on state and clear, never on load. While sout_valid is
//   high and sout_ready is low, sout and sout_last stay stable.
//
// Ports:
//   clk         in   clock
//   clear       in   synchronous active-high reset; it has priority over all
//                    other inputs and discards any in-flight or buffered word
//   load        in   upstream offers par_in
//   par_in      in   parallel word (N bits)
//   ready       out  a word can be accepted this cycle
//   sout        out  current serial bit
//   sout_valid  out  sout is valid
//   sout_ready  in   sink takes sout this cycle
//   sout_last   out  current bit is the final bit of its word
//   busy        out  a word is shifting or buffered
//   dbg_state   out  FSM state, for observation
// -----------------------------------------------------------------------------
module piso_serializer
  import serial_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] par_in,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         sout_last,
  output logic         busy,
  output ser_state_t   dbg_state
);

  localparam int CW = cnt_w(N);

  ser_state_t    state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [N-1:0]  buf_q, buf_d;
  logic          buf_full_q, buf_full_d;

  logic [CW-1:0] count;
  logic          tc;
  logic          accept;
  logic          xfer;
  logic          last_xfer;
  logic [N-1:0]  shifted;

  assign ready     = !clear && !buf_full_q;
  assign accept    = load && ready;
  assign xfer      = (state_q == S_SHIFT) && sout_ready;
  assign last_xfer = xfer && tc;

  // Vacated bits fill with zero. The direction follows the bit order on the wire.
  assign shifted = MSB_FIRST ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};

  bit_counter #(.N(N)) u_bit_counter (
    .clk     (clk),
    .clear_i (clear),
    .en_i    (xfer),
    .count_o (count),
    .tc_o    (tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      // Stay in S_SHIFT when a new word can follow directly. That word comes
      // from the buffer or from an accept on the same edge.
      S_SHIFT: if (last_xfer && !buf_full_q && !accept) state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: shift register and holding buffer
  always_comb begin
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (state_q == S_IDLE) begin
      if (accept) shreg_d = par_in;
    end else begin
      if (xfer) begin
        if (!tc) begin
          shreg_d = shifted;
        end else if (buf_full_q) begin
          shreg_d    = buf_q;
          buf_full_d = 1'b0;
        end else if (accept) begin
          shreg_d = par_in;
        end else begin
          shreg_d = shifted;
        end
      end
      // When the last bit leaves on this edge, an accepted word bypasses the
      // buffer and goes straight into the shift register (see above).
      if (accept && !last_xfer) begin
        buf_d      = par_in;
        buf_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Output logic
  always_comb begin
    sout_valid = 1'b0;
    sout       = 1'b0;
    sout_last  = 1'b0;
    if (state_q == S_SHIFT) begin
      sout_valid = 1'b1;
      sout       = MSB_FIRST ? shreg_q[N-1] : shreg_q[0];
      sout_last  = (count == CW'(N - 1));
    end
  end

  assign busy      = (state_q == S_SHIFT) || buf_full_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Two serializers share all inputs. One sends MSB first and the other LSB
// first. Each accepted word pushes its expected {last, bit} sequence into one
// queue per instance. A forked monitor pops and compares on every bit transfer
// and also checks that output stays stable under backpressure.
// -----------------------------------------------------------------------------
module tb_piso_serializer;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clear;
  logic         load;
  logic [N-1:0] par_in;
  logic         sr_dir;
  logic         rnd_bit;
  logic         rnd_bp;
  logic         sout_ready;
  assign sout_ready = rnd_bp ? rnd_bit : sr_dir;

  logic ready_m, sout_m, valid_m, last_m, busy_m;
  logic ready_l, sout_l, valid_l, last_l, busy_l;
  serial_pkg::ser_state_t dbg_m, dbg_l;

  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .load(load), .par_in(par_in), .ready(ready_m),
    .sout(sout_m), .sout_valid(valid_m), .sout_ready(sout_ready),
    .sout_last(last_m), .busy(busy_m), .dbg_state(dbg_m)
  );

  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .load(load), .par_in(par_in), .ready(ready_l),
    .sout(sout_l), .sout_valid(valid_l), .sout_ready(sout_ready),
    .sout_last(last_l), .busy(busy_l), .dbg_state(dbg_l)
  );

  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];
  int total = 0;
  int bad   = 0;
  int pops_m = 0;
  int pops_l = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: word w becomes N {last, bit} pairs in wire order.
  task automatic push_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) begin
      exp_m.push_back({(i == N - 1), w[N-1-i]});
      exp_l.push_back({(i == N - 1), w[i]});
    end
  endtask

  task automatic monitor();
    logic [1:0] hm, hl, e;
    logic       hvm, hvl;
    hvm = 1'b0;
    hvl = 1'b0;
    forever begin
      @(negedge clk);
      if (!clear) begin
        if (hvm && valid_m) check("hold_msb", {last_m, sout_m}, hm);
        if (hvl && valid_l) check("hold_lsb", {last_l, sout_l}, hl);
        if (valid_m && sout_ready) begin
          if (exp_m.size() == 0) check("sb_msb_unexpected", valid_m, 0);
          else begin
            e = exp_m.pop_front();
            check("sb_msb", {last_m, sout_m}, e);
          end
          pops_m++;
        end
        if (valid_l && sout_ready) begin
          if (exp_l.size() == 0) check("sb_lsb_unexpected", valid_l, 0);
          else begin
            e = exp_l.pop_front();
            check("sb_lsb", {last_l, sout_l}, e);
          end
          pops_l++;
        end
      end
      hvm = !clear && valid_m && !sout_ready;
      hvl = !clear && valid_l && !sout_ready;
      hm  = {last_m, sout_m};
      hl  = {last_l, sout_l};
    end
  endtask

  task automatic rnd_gen();
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  endtask

  // Called at posedge+1. It returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N-1:0] w);
    int t;
    t = 0;
    load   = 1'b1;
    par_in = w;
    @(negedge clk);
    while (!ready_m && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", ready_m, 1);
    if (ready_m) push_word(w);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Runs until both instances are idle. It counts valid cycles, busy-but-not-
  // valid gaps and cycles with ready low.
  task automatic drain(output int vc, output int gaps, output int rlo, output logic first_v);
    int t;
    t = 0; vc = 0; gaps = 0; rlo = 0;
    @(negedge clk);
    first_v = valid_m;
    while ((busy_m || busy_l) && t < 2000) begin
      if (valid_m) vc++; else gaps++;
      if (!ready_m) rlo++;
      @(negedge clk);
      t++;
    end
    check("drain_busy_msb", busy_m, 0);
    check("drain_busy_lsb", busy_l, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   vc, gaps, rlo, pm, pl, gap;
    logic fv;
    clear = 1'b1; load = 1'b0; par_in = '0;
    sr_dir = 1'b1; rnd_bit = 1'b0; rnd_bp = 1'b0;
    fork
      monitor();
      rnd_gen();
    join_none

    // Reset: clear is held for two edges.
    @(negedge clk);
    check("ready_during_clear", ready_m, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("rst_ready", ready_m, 1);
    check("rst_valid", valid_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_sout", sout_m, 0);
    check("rst_last", last_m, 0);
    check("rst_state", dbg_m, serial_pkg::S_IDLE);
    @(posedge clk);
    #1;

    // Single word
    pm = pops_m; pl = pops_l;
    send(8'hA5);
    drain(vc, gaps, rlo, fv);
    check("single_first_latency", fv, 1);
    check("single_valid_cycles", vc, 8);
    check("single_ready_low", rlo, 0);
    check("single_pops_msb", pops_m - pm, 8);
    check("single_pops_lsb", pops_l - pl, 8);

    // Back-to-back words
    pm = pops_m;
    send(8'hA5);
    send(8'h3C);
    drain(vc, gaps, rlo, fv);
    check("b2b_valid_cycles", vc, 15);
    check("b2b_gaps", gaps, 0);
    check("b2b_ready_low", rlo, 7);
    check("b2b_pops", pops_m - pm, 16);

    // Backpressure at bit index 3
    pm = pops_m;
    send(8'hA5);
    repeat (3) @(posedge clk);
    #1;
    sr_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sr_dir = 1'b1;
    drain(vc, gaps, rlo, fv);
    check("bp_valid_after", vc, 5);
    check("bp_pops", pops_m - pm, 8);
    check("bp_queue_empty", exp_m.size(), 0);

    // Clear after four bits, while a second word is buffered
    send(8'hA5);
    send(8'h3C);
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    exp_m.delete();
    exp_l.delete();
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr_valid", valid_m, 0);
    check("clr_busy", busy_m, 0);
    check("clr_busy_lsb", busy_l, 0);
    check("clr_ready", ready_m, 1);
    @(posedge clk);
    #1;
    pm = pops_m;
    send(8'hFF);
    drain(vc, gaps, rlo, fv);
    check("post_clr_valid_cycles", vc, 8);
    check("post_clr_pops", pops_m - pm, 8);

    // Word 8'h01 (the LSB-first instance sends 1 first)
    pl = pops_l;
    send(8'h01);
    drain(vc, gaps, rlo, fv);
    check("lsb_pops", pops_l - pl, 8);

    // Random words, gaps and sink backpressure
    pm = pops_m;
    rnd_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send(N'($urandom_range(0, 255)));
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_bp = 1'b0;
    drain(vc, gaps, rlo, fv);
    check("rnd_pops", pops_m - pm, 40 * N);
    check("rnd_queue_msb", exp_m.size(), 0);
    check("rnd_queue_lsb", exp_l.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
